// File: rtl/o2_pkg.sv
// Shared definitions for the front-panel loader and the CPU it feeds.
package o2_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DB_PRESS = 3'd1;
   localparam logic [2:0] ST_WRITE    = 3'd2;
   localparam logic [2:0] ST_WAIT_REL = 3'd3;
   localparam logic [2:0] ST_DB_REL   = 3'd4;

   typedef enum logic [2:0] {
      IDLE     = ST_IDLE,
      DB_PRESS = ST_DB_PRESS,
      WRITE    = ST_WRITE,
      WAIT_REL = ST_WAIT_REL,
      DB_REL   = ST_DB_REL
   } state_t;

   // 10 ms of stable button level at 48 MHz
   localparam int DB_COUNT_DEFAULT = 480000;

   // Instruction-memory depth shared with the cpu block
   localparam int CPU_MEM_DEPTH = 16;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous front-panel inputs, any width.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Front-panel instruction loader: debounced button press -> one instr_we strobe
// carrying the switch byte into the next sequential instruction slot.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | armed, waiting for the button to go high
// DB_PRESS | button high, counting stable-high cycles
// WRITE    | one cycle; strobe issued on the following edge unless full
// WAIT_REL | press consumed, waiting for the button to go low
// DB_REL   | button low, counting stable-low cycles before re-arming
module prog_loader
   import o2_pkg::*;
#(
   parameter int DB_COUNT  = DB_COUNT_DEFAULT,
   parameter int DB_W      = 20,
   parameter int MEM_DEPTH = CPU_MEM_DEPTH,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_raw,
   input  logic [7:0]        sw_raw,
   output logic              instr_we,
   output logic [7:0]        data_out,
   output logic [ADDR_W-1:0] load_addr,
   output logic              full,
   output logic              busy
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_COUNT - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

   logic       btn_s;
   logic [7:0] sw_s;

   sync2 #(.W(1)) u_sync_btn (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (btn_s)
   );

   sync2 #(.W(8)) u_sync_sw (
      .clk (clk),
      .rst (rst),
      .d   (sw_raw),
      .q   (sw_s)
   );

   state_t          state, state_nxt;
   logic [DB_W-1:0] db_cnt, db_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         db_cnt <= '0;
      end else begin
         state  <= state_nxt;
         db_cnt <= db_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      db_cnt_nxt = db_cnt;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt  = DB_PRESS;
               db_cnt_nxt = '0;
            end
         end
         DB_PRESS: begin
            if (!btn_s) begin
               state_nxt  = IDLE;
               db_cnt_nxt = '0;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = WRITE;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         WRITE: begin
            state_nxt = WAIT_REL;
         end
         WAIT_REL: begin
            if (!btn_s) begin
               state_nxt  = DB_REL;
               db_cnt_nxt = '0;
            end
         end
         DB_REL: begin
            if (btn_s) begin
               state_nxt = WAIT_REL;
            end else if (db_cnt == DB_LAST) begin
               state_nxt = IDLE;
            end else begin
               db_cnt_nxt = db_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            db_cnt_nxt = '0;
         end
      endcase
   end

   // Strobe and byte are registered off the WRITE cycle so instr_we has no
   // input-to-output path; the slot advances on the edge after the strobe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_we  <= 1'b0;
         data_out  <= 8'h00;
         load_addr <= '0;
         full      <= 1'b0;
      end else begin
         instr_we <= (state == WRITE) && !full;
         if (state == WRITE) begin
            data_out <= sw_s;
         end
         if (instr_we) begin
            if (load_addr == ADDR_LAST) begin
               full <= 1'b1;
            end else begin
               load_addr <= load_addr + 1'b1;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed + randomized bench for prog_loader against a sample-run press model.
module tb_prog_loader;

   localparam int DBC = 4;
   localparam int MD  = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_raw = 1'b0;
   logic [7:0] sw_raw = 8'h00;
   logic       instr_we;
   logic [7:0] data_out;
   logic [1:0] load_addr;
   logic       full;
   logic       busy;

   always #5 clk = ~clk;

   prog_loader #(
      .DB_COUNT  (DBC),
      .DB_W      (4),
      .MEM_DEPTH (MD),
      .ADDR_W    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_raw),
      .sw_raw    (sw_raw),
      .instr_we  (instr_we),
      .data_out  (data_out),
      .load_addr (load_addr),
      .full      (full),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Model: a press is accepted once DBC+1 consecutive high samples are seen
   // while armed; it re-arms after DBC+1 consecutive low samples.
   bit         armed = 1'b1;
   int         hi_run = 0;
   int         lo_run = 0;
   int         skip = 0;
   int         pend = -1;
   int         cnt_m = 0;
   bit         full_m = 1'b0;
   bit         exp_we = 1'b0;
   logic [7:0] data_m = 8'h00;
   bit         idle_c1 = 1'b1;
   bit         idle_c2 = 1'b1;
   bit         busy_exp = 1'b0;
   logic [7:0] sw_hist [0:65535];

   int         strobes = 0;
   int         last_we_edge = -1;
   int         last_we_addr = -1;
   int         last_we_data = -1;

   function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   function automatic void model(input int e, input logic b, input logic [7:0] s, input logic r);
      sw_hist[e] = s;
      if (!r) begin
         armed = 1'b1; hi_run = 0; lo_run = 0; skip = 0; pend = -1;
         cnt_m = 0; full_m = 1'b0; exp_we = 1'b0; data_m = 8'h00;
         idle_c1 = 1'b1; idle_c2 = 1'b1; busy_exp = 1'b0;
      end else begin
         if (exp_we) begin
            if (cnt_m == MD - 1) full_m = 1'b1;
            else cnt_m++;
         end
         exp_we = 1'b0;
         if (pend == e) begin
            data_m = sw_hist[e-2];
            exp_we = !full_m;
            pend = -1;
         end
         busy_exp = !idle_c2;
         if (armed) begin
            if (b) begin
               hi_run++;
               if (hi_run == DBC + 1) begin
                  armed = 1'b0; pend = e + 3; skip = 1; lo_run = 0;
               end
            end else begin
               hi_run = 0;
            end
         end else if (skip > 0) begin
            skip--;
         end else if (!b) begin
            lo_run++;
            if (lo_run == DBC + 1) begin
               armed = 1'b1; hi_run = 0;
            end
         end else begin
            lo_run = 0;
         end
         idle_c2 = idle_c1;
         idle_c1 = armed && (hi_run == 0);
      end
   endfunction

   task automatic step(input logic b, input logic [7:0] s, input logic r);
      btn_raw = b;
      sw_raw  = s;
      rst     = r;
      @(posedge clk);
      model(edge_n, b, s, r);
      #1;
      chk("instr_we",  32'(instr_we),  32'(exp_we));
      chk("load_addr", 32'(load_addr), 32'(cnt_m));
      chk("full",      32'(full),      32'(full_m));
      chk("data_out",  32'(data_out),  32'(data_m));
      chk("busy",      32'(busy),      32'(busy_exp));
      if (instr_we === 1'b1) begin
         strobes++;
         last_we_edge = edge_n;
         last_we_addr = int'(load_addr);
         last_we_data = int'(data_out);
      end
      edge_n++;
   endtask

   task automatic idle_cycles(input int n, input logic [7:0] s);
      for (int i = 0; i < n; i++) step(1'b0, s, 1'b1);
   endtask

   int s0;
   int f_edge;
   int len;
   bit lvl;
   bit do_rst;

   initial begin
      // reset, then clean press from edge 10
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
      chk("reset_we", 32'(instr_we), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_data", 32'(data_out), 32'h00);
      idle_cycles(6, 8'hA5);
      for (int i = 0; i < 18; i++) step(1'b1, 8'hA5, 1'b1);
      chk("clean_edge", 32'(last_we_edge), 32'd17);
      chk("clean_count", 32'(strobes), 32'd1);
      chk("clean_data", 32'(last_we_data), 32'hA5);
      chk("clean_addr", 32'(last_we_addr), 32'd0);
      chk("clean_next_addr", 32'(load_addr), 32'd1);
      idle_cycles(10, 8'h3C);

      // bounce then hold high
      s0 = strobes;
      step(1'b1, 8'h3C, 1'b1);
      step(1'b0, 8'h3C, 1'b1);
      step(1'b1, 8'h3C, 1'b1);
      step(1'b0, 8'h3C, 1'b1);
      f_edge = edge_n;
      for (int i = 0; i < 15; i++) step(1'b1, 8'h3C, 1'b1);
      chk("bounce_edge", 32'(last_we_edge), 32'(f_edge + 7));
      chk("bounce_count", 32'(strobes), 32'(s0 + 1));

      // long hold, short glitch-release, then real release and new press
      for (int i = 0; i < 100; i++) step(1'b1, 8'h3C, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h3C, 1'b1);
      for (int i = 0; i < 12; i++) step(1'b1, 8'h3C, 1'b1);
      chk("hold_count", 32'(strobes), 32'(s0 + 1));
      idle_cycles(10, 8'h5A);
      for (int i = 0; i < 12; i++) step(1'b1, 8'h5A, 1'b1);
      chk("repress_count", 32'(strobes), 32'(s0 + 2));
      chk("repress_data", 32'(last_we_data), 32'h5A);

      // fill from a fresh reset
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      s0 = strobes;
      for (int p = 1; p <= 5; p++) begin
         for (int i = 0; i < 10; i++) step(1'b1, 8'(p), 1'b1);
         idle_cycles(10, 8'(p));
      end
      chk("fill_count", 32'(strobes), 32'(s0 + 4));
      chk("fill_last_data", 32'(last_we_data), 32'h04);
      chk("fill_last_addr", 32'(last_we_addr), 32'd3);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_addr", 32'(load_addr), 32'd3);

      // reset during debounce with the button held through release
      step(1'b0, 8'h00, 1'b0);
      idle_cycles(4, 8'h77);
      s0 = strobes;
      for (int i = 0; i < 4; i++) step(1'b1, 8'h77, 1'b1);
      step(1'b1, 8'h77, 1'b0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_we", 32'(instr_we), 32'd0);
      f_edge = edge_n;
      for (int i = 0; i < 12; i++) step(1'b1, 8'h77, 1'b1);
      chk("mid_rst_count", 32'(strobes), 32'(s0 + 1));
      chk("mid_rst_edge", 32'(last_we_edge), 32'(f_edge + 7));
      chk("mid_rst_addr", 32'(last_we_addr), 32'd0);
      idle_cycles(10, 8'h00);

      // switch change right after the capture sample
      for (int i = 0; i < 15; i++) step(1'b1, (i <= 5) ? 8'h11 : 8'h22, 1'b1);
      chk("sw_change_data", 32'(last_we_data), 32'h11);
      idle_cycles(10, 8'h00);

      // randomized phases with occasional reset
      for (int ph = 0; ph < 400; ph++) begin
         len    = int'($urandom_range(12, 1));
         lvl    = 1'($urandom_range(1, 0));
         do_rst = ($urandom_range(39, 0) == 0);
         for (int k = 0; k < len; k++)
            step(lvl, 8'($urandom), (k == 0 && do_rst) ? 1'b0 : 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
